// File: rtl/imem_loader_pkg.sv
// Shared types and sizes for the instruction-memory loader
// and the instruction memory it writes.
package imem_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned INST_BYTES = 4;
  localparam int unsigned MEM_BYTES  = 88;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WRITE,
    DONE,
    ERR
  } loader_state_t;

  // Word held while its bytes are streamed out.
  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } word_t;

  // Little-endian byte lane select.
  function automatic logic [7:0] byte_lane(
    input logic [31:0] w,
    input logic [1:0]  idx
  );
    logic [7:0] b;
    unique case (idx)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      2'd3: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Instruction-word stream: host (master) offers words,
// loader (slave) accepts one when word_ready is high.
interface imem_loader_if;

  logic        word_valid;
  logic [31:0] word_data;
  logic        word_last;
  logic        word_ready;

  modport master (
    output word_valid,
    output word_data,
    output word_last,
    input  word_ready
  );

  modport slave (
    input  word_valid,
    input  word_data,
    input  word_last,
    output word_ready
  );

endinterface

// File: rtl/imem_loader.sv
// Byte-serial writer for the instruction memory.
// Ports: clk, rst_n, start, wif (word stream slave),
//   mem_we/mem_waddr/mem_wdata (byte write port),
//   core_hold, done, error (status).
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = imem_pkg::MEM_BYTES,
  parameter int unsigned ADDR_W    = XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  imem_loader_if.slave      wif,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] END_A =
    ADDR_W'(MEM_BYTES);
  localparam logic [ADDR_W-1:0] STEP =
    ADDR_W'(INST_BYTES);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [1:0]        idx_q, idx_d;
  word_t             held_q, held_d;

  logic hs;
  logic full;

  // word_ready is only ever high in ACCEPT.
  assign hs   = (state_q == ACCEPT) & wif.word_valid;
  assign full = (base_q >= END_A);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      idx_q   <= '0;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    idx_d   = idx_q;
    held_d  = held_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = ACCEPT;
          base_d  = '0;
          idx_d   = '0;
        end
      end
      ACCEPT: begin
        if (hs) begin
          if (full) begin
            // Word offered past the end: dropped.
            state_d = ERR;
          end else begin
            state_d      = WRITE;
            held_d.data  = wif.word_data;
            held_d.last  = wif.word_last;
            idx_d        = '0;
          end
        end
      end
      WRITE: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          base_d  = base_q + STEP;
          state_d = held_q.last ? DONE : ACCEPT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore decode: outputs depend on registers only.
  always_comb begin
    wif.word_ready = 1'b0;
    mem_we         = 1'b0;
    mem_waddr      = '0;
    mem_wdata      = '0;
    core_hold      = 1'b1;
    done           = 1'b0;
    error          = 1'b0;
    unique case (1'b1)
      (state_q == ACCEPT): wif.word_ready = 1'b1;
      (state_q == WRITE): begin
        mem_we    = 1'b1;
        mem_waddr = base_q + ADDR_W'(idx_q);
        mem_wdata = byte_lane(held_q.data, idx_q);
      end
      (state_q == DONE): begin
        core_hold = 1'b0;
        done      = 1'b1;
      end
      (state_q == ERR): error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed sessions
// with random words/gaps against a byte-list model.
module tb_imem_loader;
  import imem_pkg::*;

  localparam int MB = 88;
  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic          core_hold;
  logic          done;
  logic          error;

  imem_loader_if wif ();

  imem_loader #(
    .MEM_BYTES(MB),
    .ADDR_W   (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .wif      (wif.slave),
    .mem_we   (mem_we),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .core_hold(core_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Observed memory writes, as the memory samples them.
  logic [AW-1:0] wa_q[$];
  logic [7:0]    wd_q[$];
  int            bp_viol = 0;

  always @(posedge clk) begin
    if (mem_we) begin
      wa_q.push_back(mem_waddr);
      wd_q.push_back(mem_wdata);
    end
    if (mem_we && wif.word_ready) bp_viol++;
  end

  // Reference: bytes expected at addresses 0,1,2,...
  logic [7:0] exp_q[$];
  bit         exp_err;

  task automatic chk(input string tag,
                     input logic [95:0] obs,
                     input logic [95:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_word(input logic [31:0] w);
    if (exp_q.size() >= MB) begin
      exp_err = 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        exp_q.push_back(w[8*b +: 8]);
    end
  endtask

  task automatic clear_logs();
    wa_q.delete();
    wd_q.delete();
    exp_q.delete();
    exp_err = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_cnt"}, 96'(wa_q.size()),
        96'(exp_q.size()));
    for (int i = 0; i < wa_q.size() &&
                    i < exp_q.size(); i++)
      chk(tag, {wa_q[i], wd_q[i]},
          {64'(i), exp_q[i]});
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns 1ns after the handshake edge.
  task automatic send_word(input logic [31:0] w,
                           input logic l,
                           input int gap,
                           output bit ok);
    ok = 1'b0;
    @(negedge clk);
    if (gap > 0) begin
      wif.word_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    wif.word_valid = 1'b1;
    wif.word_data  = w;
    wif.word_last  = l;
    for (int i = 0; i < 60; i++) begin
      if (wif.word_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1;
    chk("handshake", 96'(ok), 96'(1));
  endtask

  task automatic wait_end();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || error) begin
        seen = 1'b1;
        break;
      end
    end
    chk("end_timeout", 96'(seen), 96'(1));
  endtask

  task automatic run_words(input int n,
                           input int maxgap);
    bit          ok;
    logic [31:0] w;
    clear_logs();
    pulse_start();
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      send_word(w, (i == n - 1),
                $urandom_range(0, maxgap), ok);
      if (ok) model_word(w);
    end
    wif.word_valid = 1'b0;
    wait_end();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    logic [31:0] w;
    logic [31:0] prog [3];

    wif.word_valid = 1'b0;
    wif.word_data  = '0;
    wif.word_last  = 1'b0;
    clear_logs();

    // Async reset, checked before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_core_hold", 96'(core_hold), 96'(1));
    chk("rst_ready", 96'(wif.word_ready), 96'(0));
    chk("rst_we", 96'(mem_we), 96'(0));
    chk("rst_done", 96'(done), 96'(0));
    chk("rst_error", 96'(error), 96'(0));
    chk("rst_waddr", 96'(mem_waddr), 96'(0));
    chk("rst_wdata", 96'(mem_wdata), 96'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_hold", 96'(core_hold), 96'(1));
    chk("idle_ready", 96'(wif.word_ready), 96'(0));

    // Three-word program, valid held high.
    prog[0] = 32'h00000913;
    prog[1] = 32'h00000433;
    prog[2] = 32'h04b40863;
    clear_logs();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      send_word(prog[i], (i == 2), 0, ok);
      if (ok) model_word(prog[i]);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("lat_we", 96'(mem_we), 96'(1));
    chk("lat_done_early", 96'(done), 96'(0));
    @(posedge clk);
    #1;
    chk("lat_done", 96'(done), 96'(1));
    chk("lat_hold", 96'(core_hold), 96'(0));
    chk("lat_ready", 96'(wif.word_ready), 96'(0));
    wif.word_valid = 1'b0;
    check_writes("w3");
    if (wd_q.size() > 10)
      chk("w3_b10", 96'(wd_q[10]), 96'(8'hb4));

    // Backpressure with random gaps.
    bp_viol = 0;
    run_words(8, 4);
    check_writes("bp");
    chk("bp_ready_in_write", 96'(bp_viol), 96'(0));
    chk("bp_done", 96'(done), 96'(1));

    // Exact fill of memory.
    run_words(MB / 4, 2);
    check_writes("fill");
    if (wa_q.size() > 0)
      chk("fill_last_addr",
          96'(wa_q[wa_q.size() - 1]), 96'(MB - 1));
    chk("fill_done", 96'(done), 96'(1));
    chk("fill_error", 96'(error), 96'(0));

    // Overflow by one word.
    run_words(MB / 4 + 1, 1);
    check_writes("ovf");
    chk("ovf_model", 96'(exp_err), 96'(1));
    chk("ovf_error", 96'(error), 96'(1));
    chk("ovf_hold", 96'(core_hold), 96'(1));
    chk("ovf_done", 96'(done), 96'(0));
    @(negedge clk);
    chk("ovf_sticky", 96'(error), 96'(1));
    run_words(1, 0);
    check_writes("ovf_restart");
    chk("ovf_clear", 96'(error), 96'(0));
    chk("ovf_restart_done", 96'(done), 96'(1));

    // Reset during byte 2 of word 5.
    clear_logs();
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      w = $urandom;
      send_word(w, 1'b0, $urandom_range(0, 2), ok);
      if (ok) model_word(w);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("mid_we", 96'(mem_we), 96'(1));
    chk("mid_addr", 96'(mem_waddr), 96'(18));
    rst_n = 1'b0;
    #1;
    chk("mid_we_drop", 96'(mem_we), 96'(0));
    chk("mid_hold", 96'(core_hold), 96'(1));
    // Bytes 16,17 landed; the rest of word 5 did not.
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    check_writes("mid");
    wif.word_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_idle_ready", 96'(wif.word_ready), 96'(0));
    chk("mid_idle_hold", 96'(core_hold), 96'(1));
    chk("mid_idle_done", 96'(done), 96'(0));
    run_words(2, 1);
    check_writes("mid_reload");
    chk("mid_reload_done", 96'(done), 96'(1));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
